telemetry_uart_tx: RTL and testbench
====================================

Name: telemetry_uart_tx

Overview:
- UART 8N1 transmitter that sends framed telemetry from the flight controller back to the ground link. It is the outbound counterpart of the command receiver on RxD.
- It latches a parallel payload on a send strobe and emits START_BYTE, the payload bytes (LSB byte first), an XOR checksum byte and STOP_BYTE on TxD.
- It sits in drone_top beside the command receiver. It is fed by the attitude/PWM logic, for example with the four motor duty bytes.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 2.
- PAYLOAD_BYTES, 4, number of payload bytes per frame; range 1..16.
- START_BYTE, 8'h0A, first byte of every frame.
- STOP_BYTE, 8'h08, last byte of every frame.

Ports:
- FCLK_CLK0_0  input  1  system clock, 50 MHz, all logic on the rising edge.
- FCLK_RESET0_N_0  input  1  reset, asynchronous assert, active-low.
- send  input  1  request strobe; sampled every cycle.
- payload  input  8*PAYLOAD_BYTES  frame payload; byte k is payload[8k+7:8k] and is sent in order k = 0 first.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when the frame is complete.
- TxD  output  1  serial output; idle level is high.

Behaviour:
- Reset (async, FCLK_RESET0_N_0 = 0):
  - TxD = 1, busy = 0, done = 0.
  - State IDLE; all counters and the shift register are cleared.
  - Asserting reset mid-frame aborts the frame: TxD goes high immediately and no done pulse is produced.
- Accept rule:
  - In IDLE, send = 1 at rising edge N latches payload into an internal register and computes chk = XOR of all payload bytes.
  - busy = 1 from edge N. TxD drives the start bit (0) from edge N.
  - Later changes to payload do not affect the frame in progress.
- Ignored requests: send while busy = 1 is ignored. It is neither queued nor does it alter the frame.
- Byte sequence: START_BYTE, payload byte 0 .. PAYLOAD_BYTES-1, chk, STOP_BYTE, giving PAYLOAD_BYTES+3 bytes in total.
- Character format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - No idle gap between characters: the next start bit follows the previous stop bit directly.
- Bit-level FSM: IDLE -> START -> DATA (bit index 0..7) -> STOP.
  - After STOP: if more bytes remain, go to START with the next byte; otherwise go to DONE.
  - DONE lasts 1 cycle, asserts done = 1 and busy = 0, then returns to IDLE.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; a bit advances on terminal count.
  - Byte index width is clog2(PAYLOAD_BYTES+3).
- Timing: total busy time is (PAYLOAD_BYTES+3) * 10 * CLKS_PER_BIT cycles. done occurs on the cycle immediately after the last stop bit period ends.
- Back-to-back: send = 1 during the DONE cycle is not accepted. The earliest acceptance is the following cycle (IDLE). This guarantees at least 1 cycle of idle high between frames.
- TxD is registered (no combinational path from inputs) and is high in IDLE and DONE.
- Payload bytes equal to START_BYTE or STOP_BYTE are sent verbatim; there is no escaping.

Test Plan:
- Single frame (CLKS_PER_BIT = 4, PAYLOAD_BYTES = 4): payload = 32'h11223344, send for 1 cycle.
  - Required: decoded bytes 0A 44 33 22 11 44 08.
  - busy high for exactly 280 cycles; a single done pulse; TxD high afterwards.
- Bit timing at default CLKS_PER_BIT = 434: every TxD transition is spaced by a multiple of 434 cycles (8.68 us).
  - Required: the first start bit falls on the accept edge and the frame lasts 7 * 4340 cycles.
- Busy rejection: pulse send again 50 cycles into a frame, with a different payload.
  - Required: the frame is unchanged and exactly one done pulse is produced.
- Back-to-back: hold send = 1 continuously with payload = 32'h0A080A08.
  - Required: two consecutive frames 0A 08 0A 08 0A 00 08, separated by exactly 1 idle-high cycle (the DONE cycle) plus acceptance.
- Reset mid-frame: deassert FCLK_RESET0_N_0 during data bit 3 of payload byte 1.
  - Required: TxD = 1 and busy = 0 immediately (asynchronously) and no done pulse.
  - After release, a new send produces a complete correct frame.
- Payload latch: change payload on the cycle after acceptance.
  - Required: the transmitted bytes and checksum match the value sampled at acceptance.

Source files
------------

// File: rtl/telemetry_uart_tx.sv
// -----------------------------------------------------------------------------
// telemetry_uart_tx
//
// UART 8N1 transmitter for the telemetry downlink. On a send strobe in IDLE it
// latches the payload and transmits one frame on TxD:
//   START_BYTE, payload byte 0 .. PAYLOAD_BYTES-1, XOR checksum, STOP_BYTE
// Characters are 1 start bit, 8 data bits LSB first and 1 stop bit. Each bit
// lasts CLKS_PER_BIT cycles. Characters follow each other with no idle gap.
//
// Ports
//   FCLK_CLK0_0      in   system clock, rising edge
//   FCLK_RESET0_N_0  in   asynchronous active-low reset
//   send             in   request strobe, accepted only in IDLE
//   payload          in   8*PAYLOAD_BYTES bits, byte k = payload[8k+7:8k]
//   busy             out  high while a frame is being transmitted
//   done             out  one-cycle pulse after the last stop bit
//   TxD              out  registered serial line, idle high
// -----------------------------------------------------------------------------
module telemetry_uart_tx #(
  parameter int         CLKS_PER_BIT  = 434,
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] START_BYTE    = 8'h0A,
  parameter logic [7:0] STOP_BYTE     = 8'h08
) (
  input  logic                       FCLK_CLK0_0,
  input  logic                       FCLK_RESET0_N_0,
  input  logic                       send,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       busy,
  output logic                       done,
  output logic                       TxD
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIDX_W = $clog2(PAYLOAD_BYTES + 3);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(PAYLOAD_BYTES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [BAUD_W-1:0]          r_baud;
  logic [2:0]                 r_bit_idx;
  logic [BIDX_W-1:0]          r_byte_idx;
  logic [7:0]                 r_shift;
  logic [8*PAYLOAD_BYTES-1:0] r_payload;
  logic [7:0]                 r_chk;
  logic                       r_txd;
  logic                       r_busy;
  logic                       r_done;

  logic                       w_baud_tc;
  logic [BIDX_W-1:0]          w_byte_idx_nxt;
  logic [7:0]                 w_next_byte;

  // XOR of all payload bytes.
  function automatic logic [7:0] payload_xor(input logic [8*PAYLOAD_BYTES-1:0] pl);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      acc = acc ^ pl[8*k +: 8];
    end
    return acc;
  endfunction

  // Frame byte at a given position: 0 = START_BYTE, 1..P = payload,
  // P+1 = checksum, P+2 = STOP_BYTE.
  function automatic logic [7:0] byte_at(input logic [BIDX_W-1:0]          idx,
                                         input logic [8*PAYLOAD_BYTES-1:0] pl,
                                         input logic [7:0]                 chk);
    logic [7:0] b;
    b = STOP_BYTE;
    if (idx == '0) begin
      b = START_BYTE;
    end else if (idx == BIDX_W'(PAYLOAD_BYTES + 1)) begin
      b = chk;
    end else begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (idx == BIDX_W'(k + 1)) b = pl[8*k +: 8];
      end
    end
    return b;
  endfunction

  assign w_baud_tc      = (r_baud == BAUD_LAST);
  assign w_byte_idx_nxt = r_byte_idx + BIDX_W'(1);
  assign w_next_byte    = byte_at(w_byte_idx_nxt, r_payload, r_chk);

  assign busy = r_busy;
  assign done = r_done;
  assign TxD  = r_txd;

  always_ff @(posedge FCLK_CLK0_0 or negedge FCLK_RESET0_N_0) begin
    if (!FCLK_RESET0_N_0) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_payload  <= '0;
      r_chk      <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Baud counter runs only while a bit is on the line.
      if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
        r_baud <= w_baud_tc ? '0 : r_baud + BAUD_W'(1);
      end else begin
        r_baud <= '0;
      end

      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (send) begin
            // Start bit goes out from the accepting edge itself.
            r_payload  <= payload;
            r_chk      <= payload_xor(payload);
            r_shift    <= START_BYTE;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_baud_tc) begin
            r_txd     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_baud_tc) begin
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        S_STOP: begin
          if (w_baud_tc) begin
            if (r_byte_idx == BYTE_LAST) begin
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Next start bit follows the stop bit with no gap.
              r_byte_idx <= w_byte_idx_nxt;
              r_shift    <= w_next_byte;
              r_txd      <= 1'b0;
              r_state    <= S_START;
            end
          end
        end

        S_DONE: begin
          // send is deliberately ignored here, leaving one idle-high cycle.
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_uart_tx.sv
module tb_telemetry_uart_tx;

  localparam int CPB        = 4;
  localparam int CPB_L      = 434;
  localparam int P          = 4;
  localparam int FRAME_BITS = (P + 3) * 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send1, send2;
  logic [31:0] pl1, pl2;
  logic        busy1, done1, txd1;
  logic        busy2, done2, txd2;

  bit          use434;
  logic        mtx, mbusy, mdone;

  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .PAYLOAD_BYTES(P)) u_dut (
    .FCLK_CLK0_0    (clk),
    .FCLK_RESET0_N_0(rst_n),
    .send           (send1),
    .payload        (pl1),
    .busy           (busy1),
    .done           (done1),
    .TxD            (txd1)
  );

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB_L), .PAYLOAD_BYTES(P)) u_dut_baud (
    .FCLK_CLK0_0    (clk),
    .FCLK_RESET0_N_0(rst_n),
    .send           (send2),
    .payload        (pl2),
    .busy           (busy2),
    .done           (done2),
    .TxD            (txd2)
  );

  assign mtx   = use434 ? txd2  : txd1;
  assign mbusy = use434 ? busy2 : busy1;
  assign mdone = use434 ? done2 : done1;

  task automatic set_send(input logic v);
    if (use434) send2 = v; else send1 = v;
  endtask

  task automatic set_pl(input logic [31:0] v);
    if (use434) pl2 = v; else pl1 = v;
  endtask

  // Reference: the i-th byte of the frame for a given payload.
  function automatic logic [7:0] exp_byte(input logic [31:0] pl, input int i);
    if (i == 0) return 8'h0A;
    if (i >= 1 && i <= P) return pl[8*(i-1) +: 8];
    if (i == P + 1) return pl[7:0] ^ pl[15:8] ^ pl[23:16] ^ pl[31:24];
    return 8'h08;
  endfunction

  // Called at the falling edge right after the accepting rising edge (k = 0).
  // Walks the frame to one cycle past the DONE cycle.
  task automatic monitor_frame(input string name, input logic [31:0] pl, input int cpb,
                               input int resend_at, input logic [31:0] resend_pl,
                               input int release_at, input bit chg);
    int total, busy_cyc, done_cnt, done_at, c, s;
    logic [7:0] rx;
    logic prev;
    total    = FRAME_BITS * cpb;
    busy_cyc = 0;
    done_cnt = 0;
    done_at  = -1;
    rx       = 8'h00;
    prev     = mtx;
    n_checks++;
    if (mtx !== 1'b0 || mbusy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: TxD=%b busy=%b, required TxD=0 busy=1", name, mtx, mbusy);
    end
    for (int k = 0; k <= total + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (chg && k == 0) set_pl(~pl);
      if (k == resend_at) begin set_send(1'b1); set_pl(resend_pl); end
      if (resend_at >= 0 && k == resend_at + 1) set_send(1'b0);
      if (k == release_at) set_send(1'b0);
      if (mbusy === 1'b1) busy_cyc++;
      if (mdone === 1'b1) begin done_cnt++; done_at = k; end
      if (k > 0 && k <= total && mtx !== prev) begin
        n_checks++;
        if ((k % cpb) != 0) begin
          n_fail++;
          $display("FAIL %s edge_spacing: transition at cycle %0d, required multiple of %0d", name, k, cpb);
        end
      end
      prev = mtx;
      if (k < total && (k % cpb) == cpb / 2) begin
        c = k / (10 * cpb);
        s = (k / cpb) % 10;
        if (s == 0) begin
          n_checks++;
          if (mtx !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_bit char %0d: got %b, required 0", name, c, mtx);
          end
        end else if (s == 9) begin
          n_checks++;
          if (mtx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stop_bit char %0d: got %b, required 1", name, c, mtx);
          end
        end else begin
          rx[s-1] = mtx;
          if (s == 8) begin
            n_checks++;
            if (rx !== exp_byte(pl, c)) begin
              n_fail++;
              $display("FAIL %s byte %0d: got %02h, required %02h", name, c, rx, exp_byte(pl, c));
            end
          end
        end
      end
    end
    n_checks++;
    if (busy_cyc != total) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cyc, total);
    end
    n_checks++;
    if (done_cnt != 1 || done_at != total) begin
      n_fail++;
      $display("FAIL %s done_pulse: count %0d at cycle %0d, required 1 at %0d", name, done_cnt, done_at, total);
    end
    n_checks++;
    if (mtx !== 1'b1 || mbusy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_frame: TxD=%b busy=%b, required TxD=1 busy=0", name, mtx, mbusy);
    end
  endtask

  task automatic launch(input logic [31:0] v);
    set_pl(v);
    set_send(1'b1);
    @(negedge clk);
    set_send(1'b0);
  endtask

  task automatic test_reset;
    n_checks++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: TxD=%b busy=%b done=%b, required 1 0 0", txd1, busy1, done1);
    end
    n_checks++;
    if (txd2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_baud: TxD=%b busy=%b done=%b, required 1 0 0", txd2, busy2, done2);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: TxD=%b busy=%b done=%b, required 1 0 0", txd1, busy1, done1);
    end
  endtask

  task automatic test_single_frame;
    logic [31:0] v;
    launch(32'h11223344);
    monitor_frame("single", 32'h11223344, CPB, -1, 32'h0, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      v = $urandom();
      launch(v);
      monitor_frame("random", v, CPB, -1, 32'h0, -1, 1'b0);
    end
  endtask

  task automatic test_busy_reject;
    logic [31:0] v;
    v = $urandom();
    launch(v);
    monitor_frame("busy_reject", v, CPB, 50, ~v, -1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || txd1 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_reject_queued: busy=%b TxD=%b, required busy=0 TxD=1", busy1, txd1);
    end
  endtask

  task automatic test_payload_latch;
    logic [31:0] v;
    v = $urandom();
    launch(v);
    monitor_frame("payload_latch", v, CPB, -1, 32'h0, -1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int total;
    total = FRAME_BITS * CPB;
    set_pl(32'h0A080A08);
    set_send(1'b1);
    @(negedge clk);
    monitor_frame("b2b_first", 32'h0A080A08, CPB, -1, 32'h0, -1, 1'b0);
    @(negedge clk);
    monitor_frame("b2b_second", 32'h0A080A08, CPB, -1, 32'h0, total + 1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_third: busy=%b, required 0", busy1);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int dcnt;
    dcnt = 0;
    v = $urandom();
    launch(v);
    // data bit 3 of payload byte 1 (frame byte 2)
    for (int k = 1; k <= 2 * 10 * CPB + 4 * CPB + 1; k++) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_busy: busy=%b, required 1", busy1);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: TxD=%b busy=%b done=%b, required 1 0 0", txd1, busy1, done1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) dcnt++;
    end
    n_checks++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", dcnt);
    end
    v = $urandom();
    launch(v);
    monitor_frame("after_reset", v, CPB, -1, 32'h0, -1, 1'b0);
  endtask

  task automatic test_bit_timing_default;
    logic [31:0] v;
    use434 = 1'b1;
    v = $urandom();
    launch(v);
    monitor_frame("baud434", v, CPB_L, -1, 32'h0, -1, 1'b0);
    use434 = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    send1  = 1'b0;
    send2  = 1'b0;
    pl1    = 32'h0;
    pl2    = 32'h0;
    use434 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_frame();
    repeat (3) @(negedge clk);
    test_busy_reject();
    repeat (3) @(negedge clk);
    test_payload_latch();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    test_bit_timing_default();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
